hdmi_tx_init_sequencer: RTL and testbench

//  Walks a register table and writes each entry into the HDMI transmitter over a byte-write I2C master.

---
 rtl/hdmi_tx_init_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_hdmi_tx_init_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_tx_init_sequencer.sv
// rtl/hdmi_tx_init_sequencer.sv - HDMI transmitter register-table init sequencer
//
// Walks the register table ROM and writes every entry into the HDMI transmitter
// through a byte-write I2C master. It waits a power-up delay before the first
// write and leaves an idle gap after every transaction. A NACKed entry is retried
// up to MAX_RETRIES attempts in total. A falling edge on the transmitter interrupt
// (hot-plug) re-runs the whole table.
//
// Ports:
//   iCLK        system clock
//   iRST_N      synchronous reset, active low
//   iTX_INT     transmitter interrupt, active low, asynchronous
//   oTBL_ADDR   table index presented to the registered ROM
//   iTBL_DATA   {reg_addr, value}, valid one cycle after oTBL_ADDR changes
//   oI2C_REQ    write request to the I2C master, held until iI2C_DONE
//   oI2C_DEV    device write address (constant DEV_ADDR)
//   oI2C_REG    register address of the current write
//   oI2C_DATA   data byte of the current write
//   iI2C_DONE   one-cycle pulse: transaction finished
//   iI2C_NACK   slave NACKed, qualified by iI2C_DONE
//   oCFG_DONE   whole table written successfully
//   oCFG_ERR    an entry failed MAX_RETRIES times
//   oBUSY       sequence in progress
`timescale 1ns/1ps
module hdmi_tx_init_sequencer #(
  parameter int         NUM_REGS    = 31,
  parameter logic [7:0] DEV_ADDR    = 8'h72,
  parameter int         PWRUP_CYC   = 5_000_000,
  parameter int         GAP_CYC     = 500,
  parameter int         MAX_RETRIES = 3
) (
  input  logic                                             iCLK,
  input  logic                                             iRST_N,
  input  logic                                             iTX_INT,
  output logic [((NUM_REGS > 1) ? $clog2(NUM_REGS) : 1)-1:0] oTBL_ADDR,
  input  logic [15:0]                                      iTBL_DATA,
  output logic                                             oI2C_REQ,
  output logic [7:0]                                       oI2C_DEV,
  output logic [7:0]                                       oI2C_REG,
  output logic [7:0]                                       oI2C_DATA,
  input  logic                                             iI2C_DONE,
  input  logic                                             iI2C_NACK,
  output logic                                             oCFG_DONE,
  output logic                                             oCFG_ERR,
  output logic                                             oBUSY
);

  localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_MAX = (PWRUP_CYC > GAP_CYC) ? PWRUP_CYC : GAP_CYC;
  localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int RET_W   = ($clog2(MAX_RETRIES + 1) > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // Terminal counts: a phase of N cycles ends on the edge that sees count N-1.
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'((PWRUP_CYC > 0) ? PWRUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_PWRUP,
    S_LOAD,
    S_REQ,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]   r_idx, w_idx_nx;
  logic [RET_W-1:0]   r_ret, w_ret_nx;
  logic               r_last, w_last_nx;
  logic               r_pending, w_pending_nx;
  logic               r_req, w_req_nx;
  logic [7:0]         r_reg, w_reg_nx;
  logic [7:0]         r_data, w_data_nx;
  logic               r_done, w_done_nx;
  logic               r_err, w_err_nx;
  logic               r_busy, w_busy_nx;
  logic               r_sync1, r_sync2;
  logic               w_int_edge;
  logic               w_restart;

  // Synchronisers are deliberately left out of reset so that an interrupt
  // line already held low across reset is not mistaken for a new edge.
  assign w_int_edge = ~r_sync1 & r_sync2;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_idx_nx     = r_idx;
    w_ret_nx     = r_ret;
    w_last_nx    = r_last;
    w_pending_nx = r_pending;
    w_req_nx     = r_req;
    w_reg_nx     = r_reg;
    w_data_nx    = r_data;
    w_restart    = 1'b0;

    // Mid-pass interrupts are remembered; the pass finishes and then re-runs.
    if (w_int_edge && (r_state != S_DONE) && (r_state != S_ERROR)) begin
      w_pending_nx = 1'b1;
    end

    case (r_state)
      S_PWRUP: begin
        if (r_cnt >= PWR_LAST) begin
          w_state_nx = S_LOAD;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_LOAD: begin
        w_state_nx = S_REQ;
        w_req_nx   = 1'b1;
        w_reg_nx   = iTBL_DATA[15:8];
        w_data_nx  = iTBL_DATA[7:0];
      end
      S_REQ: begin
        if (iI2C_DONE) begin
          w_req_nx = 1'b0;
          if (!iI2C_NACK) begin
            w_ret_nx   = '0;
            w_state_nx = S_GAP;
            w_cnt_nx   = '0;
            if (r_idx == IDX_LAST) begin
              w_last_nx = 1'b1;
            end else begin
              w_idx_nx = r_idx + IDX_W'(1);
            end
          end else if ((int'(r_ret) + 1) < MAX_RETRIES) begin
            w_ret_nx   = r_ret + RET_W'(1);
            w_state_nx = S_GAP;
            w_cnt_nx   = '0;
          end else if (r_pending || w_int_edge) begin
            w_restart = 1'b1;
          end else begin
            w_state_nx = S_ERROR;
          end
        end
      end
      S_GAP: begin
        if (r_cnt >= GAP_LAST) begin
          w_cnt_nx = '0;
          if (!r_last) begin
            w_state_nx = S_LOAD;
          end else if (r_pending || w_int_edge) begin
            w_restart = 1'b1;
          end else begin
            w_state_nx = S_DONE;
          end
        end else begin
          w_cnt_nx = r_cnt + CNT_W'(1);
        end
      end
      S_DONE, S_ERROR: begin
        if (w_int_edge) begin
          w_restart = 1'b1;
        end
      end
      default: begin
        w_restart = 1'b1;
      end
    endcase

    // Restart keeps the last written reg/data on the bus; only reset clears them.
    if (w_restart) begin
      w_state_nx   = S_PWRUP;
      w_cnt_nx     = '0;
      w_idx_nx     = '0;
      w_ret_nx     = '0;
      w_last_nx    = 1'b0;
      w_pending_nx = 1'b0;
      w_req_nx     = 1'b0;
    end

    w_done_nx = (w_state_nx == S_DONE);
    w_err_nx  = (w_state_nx == S_ERROR);
    w_busy_nx = !(w_done_nx || w_err_nx);
  end

  always_ff @(posedge iCLK) begin
    r_sync1 <= iTX_INT;
    r_sync2 <= r_sync1;
    if (!iRST_N) begin
      r_state   <= S_PWRUP;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_ret     <= '0;
      r_last    <= 1'b0;
      r_pending <= 1'b0;
      r_req     <= 1'b0;
      r_reg     <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_idx     <= w_idx_nx;
      r_ret     <= w_ret_nx;
      r_last    <= w_last_nx;
      r_pending <= w_pending_nx;
      r_req     <= w_req_nx;
      r_reg     <= w_reg_nx;
      r_data    <= w_data_nx;
      r_done    <= w_done_nx;
      r_err     <= w_err_nx;
      r_busy    <= w_busy_nx;
    end
  end

  assign oTBL_ADDR = r_idx;
  assign oI2C_REQ  = r_req;
  assign oI2C_DEV  = DEV_ADDR;
  assign oI2C_REG  = r_reg;
  assign oI2C_DATA = r_data;
  assign oCFG_DONE = r_done;
  assign oCFG_ERR  = r_err;
  assign oBUSY     = r_busy;

endmodule

// File: tb/tb_hdmi_tx_init_sequencer.sv
// tb/tb_hdmi_tx_init_sequencer.sv - self-checking bench for hdmi_tx_init_sequencer
`timescale 1ns/1ps
module tb_hdmi_tx_init_sequencer;

  localparam int NUM_REGS    = 4;
  localparam int PWRUP_CYC   = 10;
  localparam int GAP_CYC     = 2;
  localparam int MAX_RETRIES = 3;
  localparam int LAT         = 5;
  localparam int MAXT        = 400;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_int = 1'b1;
  logic [1:0]  tbl_addr;
  logic [15:0] tbl_data = 16'h0;
  logic        i2c_req;
  logic [7:0]  i2c_dev, i2c_reg, i2c_data;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        cfg_done, cfg_err, busy;

  always #5 clk = ~clk;

  hdmi_tx_init_sequencer #(
    .NUM_REGS(NUM_REGS), .DEV_ADDR(8'h72), .PWRUP_CYC(PWRUP_CYC),
    .GAP_CYC(GAP_CYC), .MAX_RETRIES(MAX_RETRIES)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iTX_INT(tx_int),
    .oTBL_ADDR(tbl_addr), .iTBL_DATA(tbl_data),
    .oI2C_REQ(i2c_req), .oI2C_DEV(i2c_dev), .oI2C_REG(i2c_reg), .oI2C_DATA(i2c_data),
    .iI2C_DONE(i2c_done), .iI2C_NACK(i2c_nack),
    .oCFG_DONE(cfg_done), .oCFG_ERR(cfg_err), .oBUSY(busy)
  );

  logic [15:0] rom [NUM_REGS] = '{16'h4110, 16'h9803, 16'h9AE0, 16'hD6C0};
  int          plan_nack [NUM_REGS];
  int          scen = 0;
  int          tcur = 0;

  // Cycle index: value after the reset edge is cycle 0.
  always @(posedge clk) begin
    if (!rst_n) tcur = 0;
    else        tcur = tcur + 1;
  end

  // Registered ROM plus I2C master answering LAT cycles after the request rises.
  logic [1:0] rom_q = 2'd0;
  int         m_cnt = 0;
  int         m_scen = 0;
  int         m_used [NUM_REGS];
  always begin
    @(posedge clk);
    #1;
    tbl_data = rom[rom_q];
    rom_q    = tbl_addr;
    if (m_scen != scen) begin
      m_scen = scen;
      for (int i = 0; i < NUM_REGS; i++) m_used[i] = 0;
    end
    if (i2c_req) m_cnt = m_cnt + 1;
    else         m_cnt = 0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (i2c_req && m_cnt == LAT) begin
      i2c_done = 1'b1;
      if (m_used[tbl_addr] < plan_nack[tbl_addr]) begin
        i2c_nack = 1'b1;
        m_used[tbl_addr] = m_used[tbl_addr] + 1;
      end
    end
  end

  // Observation monitor for the literal checks.
  int   req_rises, first_done, n98, mon_scen;
  int   rise_at [16];
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    if (mon_scen != scen) begin
      mon_scen = scen;
      req_rises = 0; first_done = -1; n98 = 0;
      for (int i = 0; i < 16; i++) rise_at[i] = -1;
    end
    if (i2c_req && !prev_req) begin
      if (req_rises < 16) rise_at[req_rises] = tcur;
      req_rises = req_rises + 1;
      if (i2c_reg == 8'h98) n98 = n98 + 1;
    end
    if (cfg_done && first_done < 0) first_done = tcur;
    prev_req = i2c_req;
  end

  // Timeline model: expected {req, addr, reg, data, done, err, busy} per cycle.
  logic [21:0] exp_vec [MAXT];
  int          tl_len;
  int          req_start [NUM_REGS];
  logic [1:0]  m_addr;
  logic [7:0]  m_reg, m_data;

  task automatic push(input int n, input bit req, input bit done, input bit err, input bit bsy);
    for (int i = 0; i < n; i++) begin
      if (tl_len < MAXT) begin
        exp_vec[tl_len] = {req, m_addr, m_reg, m_data, done, err, bsy};
        tl_len = tl_len + 1;
      end
    end
  endtask

  task automatic model_reset();
    tl_len = 0; m_addr = 2'd0; m_reg = 8'h00; m_data = 8'h00;
  endtask

  // Power-up wait then the one ROM-latency cycle; index returns to 0.
  task automatic model_pwrup();
    m_addr = 2'd0;
    push(PWRUP_CYC + 1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // One table pass. Ends just after the final gap (ACK) or at the error cycle.
  task automatic model_pass(output bit failed);
    int tries;
    bit acked;
    failed = 1'b0;
    for (int i = 0; i < NUM_REGS && !failed; i++) begin
      tries = 0; acked = 1'b0;
      m_addr = 2'(i);
      while (!acked && !failed) begin
        if (tries == 0) req_start[i] = tl_len;
        m_reg = rom[i][15:8]; m_data = rom[i][7:0];
        push(LAT, 1'b1, 1'b0, 1'b0, 1'b1);
        tries = tries + 1;
        if (tries <= plan_nack[i]) begin
          if (tries == MAX_RETRIES) failed = 1'b1;
          else push(GAP_CYC + 1, 1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
          acked = 1'b1;
          if (i < NUM_REGS - 1) begin
            m_addr = 2'(i + 1);
            push(GAP_CYC + 1, 1'b0, 1'b0, 1'b0, 1'b1);
          end else begin
            push(GAP_CYC, 1'b0, 1'b0, 1'b0, 1'b1);
          end
        end
      end
    end
  endtask

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [21:0] got;

  task automatic chk(input string name, input int act, input int expv);
    n_tests = n_tests + 1;
    if (act != expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic run_scen(input string name, input int int_at, input int int_len, input int rst_at);
    bit rst_used;
    int guard;
    rst_used = 1'b0; guard = 0;
    tx_int = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    scen = scen + 1;
    while (tcur < tl_len && guard < 3000) begin
      if (tcur == int_at) tx_int = 1'b0;
      if (tcur == int_at + int_len) tx_int = 1'b1;
      if (!rst_used && tcur == rst_at) begin
        rst_n = 1'b0; rst_used = 1'b1;
      end else begin
        rst_n = 1'b1;
      end
      @(negedge clk);
      got = {i2c_req, tbl_addr, i2c_reg, i2c_data, cfg_done, cfg_err, busy};
      n_tests = n_tests + 1;
      if (got !== exp_vec[tcur]) begin
        n_fail = n_fail + 1;
        $display("FAIL %s cycle %0d: got req=%b addr=%0d reg=%h data=%h done=%b err=%b busy=%b expected req=%b addr=%0d reg=%h data=%h done=%b err=%b busy=%b",
                 name, tcur, got[21], got[20:19], got[18:11], got[10:3], got[2], got[1], got[0],
                 exp_vec[tcur][21], exp_vec[tcur][20:19], exp_vec[tcur][18:11], exp_vec[tcur][10:3],
                 exp_vec[tcur][2], exp_vec[tcur][1], exp_vec[tcur][0]);
      end
      @(posedge clk); #1;
      guard = guard + 1;
    end
    rst_n = 1'b1;
    tx_int = 1'b1;
    if (guard >= 3000) chk({name, "_timeout"}, guard, 0);
  endtask

  initial begin
    bit f;
    int int_at;
    int rst_at;
    for (int i = 0; i < NUM_REGS; i++) plan_nack[i] = 0;
    repeat (3) @(posedge clk);
    #1;

    // 1: clean pass
    model_reset(); model_pwrup(); model_pass(f); push(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scen("t1_clean", -1, 0, -1);
    chk("t1_dev", int'(i2c_dev), 8'h72);
    chk("t1_req_count", req_rises, 4);
    chk("t1_first_req", rise_at[0], 11);
    chk("t1_done_cycle", first_done, 42);

    // 2: entry 1 NACKed twice
    plan_nack[1] = 2;
    model_reset(); model_pwrup(); model_pass(f); push(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scen("t2_retry", -1, 0, -1);
    chk("t2_reg98_attempts", n98, 3);
    chk("t2_done_cycle", first_done, 58);
    chk("t2_err", int'(cfg_err), 0);
    plan_nack[1] = 0;

    // 3: entry 2 NACKed to exhaustion
    plan_nack[2] = 3;
    model_reset(); model_pwrup(); model_pass(f); push(20, 1'b0, 1'b0, 1'b1, 1'b0);
    run_scen("t3_error", -1, 0, -1);
    chk("t3_err", int'(cfg_err), 1);
    chk("t3_busy", int'(busy), 0);
    chk("t3_done", int'(cfg_done), 0);
    chk("t3_addr", int'(tbl_addr), 2);
    chk("t3_req_count", req_rises, 5);
    plan_nack[2] = 0;

    // 4: interrupt while DONE, line held low for 10 cycles
    model_reset(); model_pwrup(); model_pass(f); push(5, 1'b0, 1'b1, 1'b0, 1'b0);
    int_at = tl_len - 2;
    model_pwrup(); model_pass(f); push(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scen("t4_int_done", int_at, 10, -1);
    chk("t4_req_count", req_rises, 8);
    chk("t4_second_first_req", rise_at[4], 58);

    // 5: interrupt during entry 1 of the pass
    model_reset(); model_pwrup(); model_pass(f);
    int_at = req_start[1] + 1;
    model_pwrup(); model_pass(f); push(6, 1'b0, 1'b1, 1'b0, 1'b0);
    run_scen("t5_int_pending", int_at, 3, -1);
    chk("t5_req_count", req_rises, 8);
    chk("t5_done_cycle", first_done, 84);
    chk("t5_second_first_req", rise_at[4], 53);

    // 6: one-cycle reset while entry 2 is requesting
    model_reset(); model_pwrup(); model_pass(f); push(6, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_at = req_start[2] + 1;
    run_scen("t6_reset_mid", -1, 0, rst_at);
    chk("t6_req_count", req_rises, 7);
    chk("t6_done", int'(cfg_done), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
